spi_master_tx: RTL and testbench

SPI_MASTER_TX -- requirements
Module: spi_master_tx

---
 rtl/spi_master_tx.sv | 156 +++++++++++++++
 tb/tb_spi_master_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_tx
// Description : Transmit-only SPI master for LCD-style links. Sends one frame
//               of 1..DATA_W bits with a latched data/command line, holds CS
//               high for WAIT cycles after each frame, then pulses o_done.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_tx #(
  parameter int DATA_W    = 16,
  parameter int CLK_DIV   = 2,
  parameter int WAIT      = 10,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [DATA_W-1:0]       i_data,
  input  logic [$clog2(DATA_W):0] i_len,
  input  logic                    i_dc,
  input  logic                    i_we,
  output logic                    o_sclk,
  output logic                    o_mosi,
  output logic                    o_cs,
  output logic                    o_dc,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int LEN_W    = $clog2(DATA_W) + 1;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W    = (WAIT > 1) ? $clog2(WAIT) : 1;
  localparam int GAP_LAST = (WAIT > 0) ? WAIT - 1 : 0;

  localparam logic              CPOL_L   = (CPOL != 0);
  localparam logic              CPHA_L   = (CPHA != 0);
  localparam logic              MSB_L    = (MSB_FIRST != 0);
  localparam logic [LEN_W-1:0]  FULL_LEN = LEN_W'(DATA_W);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_END  = GAP_W'(GAP_LAST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [DIV_W-1:0]   div_cnt;    // position inside the current half period
  logic               half_b;     // 0 = half A, 1 = half B of the bit period
  logic [LEN_W-1:0]   bits_left;  // bits still to send, including current one
  logic [GAP_W-1:0]   gap_cnt;
  logic [DATA_W-1:0]  shreg;
  logic               dc_q;

  logic [LEN_W-1:0]   eff_len;
  logic [LEN_W-1:0]   shamt;
  logic               div_end;
  logic               bit_end;
  logic               last_bit;
  logic               gap_end;

  // Zero or oversize lengths fall back to a full-width frame; for MSB-first
  // the payload is left-justified so bit len-1 sits at the shift-out end.
  assign eff_len  = ((i_len == '0) || (i_len > FULL_LEN)) ? FULL_LEN : i_len;
  assign shamt    = FULL_LEN - eff_len;

  assign div_end  = (div_cnt == DIV_LAST);
  assign bit_end  = div_end && half_b;
  assign last_bit = (bits_left == LEN_W'(1));
  assign gap_end  = (gap_cnt == GAP_END);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a zero WAIT skips the gap state entirely
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_we) state_nxt = SHIFT;
      SHIFT:   if (bit_end && last_bit) state_nxt = (WAIT == 0) ? DONE : GAP;
      GAP:     if (gap_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath: capture on accept, divide and shift while in SHIFT, count the gap
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt   <= '0;
      half_b    <= 1'b0;
      bits_left <= '0;
      gap_cnt   <= '0;
      shreg     <= '0;
      dc_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_cnt <= '0;
          half_b  <= 1'b0;
          gap_cnt <= '0;
          if (i_we) begin
            shreg     <= MSB_L ? (i_data << shamt) : i_data;
            bits_left <= eff_len;
            dc_q      <= i_dc;
          end
        end
        SHIFT: begin
          if (div_end) begin
            div_cnt <= '0;
            half_b  <= ~half_b;
            if (half_b) begin
              shreg     <= MSB_L ? (shreg << 1) : (shreg >> 1);
              bits_left <= bits_left - LEN_W'(1);
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: begin
          gap_cnt <= '0;
        end
      endcase
    end
  end

  // Outputs decode directly from registered state so reset takes effect at once
  always_comb begin
    o_busy = (state != IDLE);
    o_done = (state == DONE);
    o_cs   = (state != SHIFT);
    o_dc   = dc_q;
    o_sclk = CPOL_L;
    o_mosi = 1'b0;
    if (state == SHIFT) begin
      o_sclk = (half_b ^ CPHA_L) ? ~CPOL_L : CPOL_L;
      o_mosi = MSB_L ? shreg[DATA_W-1] : shreg[0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_tx
// Description : Scoreboard bench for spi_master_tx. dut0 runs mode 0,
//               MSB-first, CLK_DIV=2, WAIT=10; dut1 runs mode 3, LSB-first,
//               CLK_DIV=3, WAIT=0. Stimulus pushes expected frames; a monitor
//               reassembles MOSI on SCLK rising edges and checks at o_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_tx;

  typedef struct {
    logic [31:0] seq;    // bits in wire order, first bit sent is the MSB
    int          nbits;
    logic        dc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0][15:0] data_i = '0;
  logic [1:0][4:0]  len_i = '0;
  logic [1:0]       dc_i = '0;
  logic [1:0]       we_i = '0;
  logic [1:0]       sclk, mosi, cs, dc_o, busy, done;

  exp_t q0[$];
  exp_t q1[$];

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int          t0[2];
  int          nb[2];
  int          csl[2];
  int          viol[2];
  logic [31:0] cap[2];
  logic        pbusy[2];
  logic        psclk[2];

  always #5 clk = ~clk;

  spi_master_tx #(
    .DATA_W(16), .CLK_DIV(2), .WAIT(10), .CPOL(0), .CPHA(0), .MSB_FIRST(1)
  ) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data_i[0]), .i_len(len_i[0]),
    .i_dc(dc_i[0]), .i_we(we_i[0]), .o_sclk(sclk[0]), .o_mosi(mosi[0]),
    .o_cs(cs[0]), .o_dc(dc_o[0]), .o_busy(busy[0]), .o_done(done[0])
  );

  spi_master_tx #(
    .DATA_W(16), .CLK_DIV(3), .WAIT(0), .CPOL(1), .CPHA(1), .MSB_FIRST(0)
  ) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data_i[1]), .i_len(len_i[1]),
    .i_dc(dc_i[1]), .i_we(we_i[1]), .o_sclk(sclk[1]), .o_mosi(mosi[1]),
    .o_cs(cs[1]), .o_dc(dc_o[1]), .o_busy(busy[1]), .o_done(done[1])
  );

  function automatic logic cpol_of(input int d);
    return (d == 1);
  endfunction

  function automatic int div_of(input int d);
    return (d == 1) ? 3 : 2;
  endfunction

  function automatic int wait_of(input int d);
    return (d == 1) ? 0 : 10;
  endfunction

  task automatic chk(input string nm, input int d, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h, required 0x%0h", nm, d, act, req);
    end
  endtask

  // Monitor: rebuild each frame from the wires and score it when o_done pulses
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (busy[d] && !pbusy[d]) begin
        t0[d]  = cyc;
        cap[d] = '0;
        nb[d]  = 0;
        csl[d] = 0;
      end
      if (busy[d]) begin
        if (!cs[d]) csl[d]++;
        if (sclk[d] && !psclk[d]) begin
          cap[d] = {cap[d][30:0], mosi[d]};
          nb[d]++;
        end
      end
      if (cs[d] && ((mosi[d] !== 1'b0) || (sclk[d] !== cpol_of(d)))) viol[d]++;
      if (done[d]) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          n_vec++;
          n_fail++;
          $display("FAIL spurious_done dut%0d: got o_done with no frame pending, required none", d);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk("mosi_seq",   d, cap[d], e.seq);
          chk("sclk_count", d, nb[d], e.nbits);
          chk("cs_low",     d, csl[d], e.nbits * 2 * div_of(d));
          chk("done_cycle", d, cyc - t0[d] + 1, e.nbits * 2 * div_of(d) + wait_of(d) + 1);
          chk("dc_latch",   d, dc_o[d], e.dc);
          chk("busy_at_done", d, busy[d], 1);
          chk("idle_lines", d, viol[d], 0);
        end
        viol[d] = 0;
      end
      pbusy[d] = busy[d];
      psclk[d] = sclk[d];
    end
    cyc++;
  end

  // Start one frame on the first idle cycle; returns at the negedge of cycle 1
  task automatic send(input int d, input logic [15:0] dat, input logic [4:0] ln,
                      input logic dcv, input logic [31:0] seq, input int nbits,
                      input bit push);
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 500 && busy[d]; i++) @(negedge clk);
    if (busy[d]) chk("idle_timeout", d, busy[d], 0);
    data_i[d] = dat;
    len_i[d]  = ln;
    dc_i[d]   = dcv;
    we_i[d]   = 1'b1;
    e.seq = seq; e.nbits = nbits; e.dc = dcv;
    if (push) begin
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(negedge clk);
    we_i[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      viol[d] = 0; pbusy[d] = 1'b0; psclk[d] = cpol_of(d);
      cap[d] = '0; nb[d] = 0; csl[d] = 0; t0[d] = 0;
    end
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_cs",   0, cs[0], 1);
    chk("rst_sclk", 0, sclk[0], 0);
    chk("rst_mosi", 0, mosi[0], 0);
    chk("rst_busy", 0, busy[0], 0);
    chk("rst_done", 0, done[0], 0);
    chk("rst_dc",   0, dc_o[0], 0);
    chk("rst_cs",   1, cs[1], 1);
    chk("rst_sclk", 1, sclk[1], 1);
    #1 rst_n = 1'b1;

    // 0xA55A with i_we pulsed at cycles 5 and 75 (done cycle) -> both ignored
    send(0, 16'hA55A, 5'd16, 1'b0, 32'hA55A, 16, 1'b1);
    repeat (4) @(negedge clk);
    data_i[0] = 16'hFFFF; len_i[0] = 5'd3; dc_i[0] = 1'b1; we_i[0] = 1'b1;
    chk("busy_c5", 0, busy[0], 1);
    @(negedge clk);
    we_i[0] = 1'b0;
    repeat (69) @(negedge clk);
    we_i[0] = 1'b1;
    chk("done_c75", 0, done[0], 1);
    @(negedge clk);
    we_i[0] = 1'b0;
    chk("no_queue", 0, busy[0], 0);
    repeat (3) @(negedge clk);
    chk("still_idle", 0, busy[0], 0);

    send(0, 16'h003C, 5'd8,  1'b1, 32'h3C,   8,  1'b1);
    for (int i = 0; i < 200 && busy[0]; i++) @(negedge clk);
    chk("dc_hold", 0, dc_o[0], 1);
    send(0, 16'h1234, 5'd0,  1'b0, 32'h1234, 16, 1'b1);
    send(0, 16'hC3A5, 5'd31, 1'b1, 32'hC3A5, 16, 1'b1);
    send(0, 16'hFF0F, 5'd4,  1'b0, 32'hF,    4,  1'b1);
    send(0, 16'hFFE0, 5'd5,  1'b1, 32'h0,    5,  1'b1);
    send(0, 16'hFFFE, 5'd2,  1'b0, 32'h2,    2,  1'b1);

    // reset at cycle 20 of a 16-bit frame aborts it immediately
    send(0, 16'hFFFF, 5'd16, 1'b1, 32'hFFFF, 16, 1'b0);
    repeat (19) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_cs",   0, cs[0], 1);
    chk("abort_sclk", 0, sclk[0], 0);
    chk("abort_busy", 0, busy[0], 0);
    chk("abort_mosi", 0, mosi[0], 0);
    chk("abort_dc",   0, dc_o[0], 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    send(0, 16'h5A5A, 5'd16, 1'b0, 32'h5A5A, 16, 1'b1);

    // mode 3, LSB first, direct SHIFT->DONE
    send(1, 16'h0001, 5'd4, 1'b0, 32'h8,    4,  1'b1);
    send(1, 16'h00B2, 5'd8, 1'b1, 32'h4D,   8,  1'b1);
    send(1, 16'h0003, 5'd0, 1'b0, 32'hC000, 16, 1'b1);

    for (int i = 0; i < 3000 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    chk("pending_frames", 0, q0.size() + q1.size(), 0);
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
